// File: rtl/vga_rx.sv
`timescale 1ns/1ps
// VGA timing receiver: checks h/v sync against nominal timing, locks after one
// clean frame, and emits pixel coordinates plus colour for the visible area.
//
// state  | meaning
// SEARCH | no timing reference; errors ignored, wait for v leading edge
// CHECK  | observing one full frame; any error restarts the observation
// LOCKED | timing trusted; pixels emitted, first error drops back to SEARCH
module vga_rx #(
    parameter int   H_DISP   = 800,
    parameter int   H_SYNC   = 128,
    parameter int   H_BACK   = 88,
    parameter int   H_TOTAL  = 1056,
    parameter int   V_DISP   = 600,
    parameter int   V_SYNC   = 4,
    parameter int   V_BACK   = 23,
    parameter int   V_TOTAL  = 628,
    parameter logic SYNC_POL = 1'b1,
    parameter int   C_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 h_sync_i,
    input  logic                 v_sync_i,
    input  logic [C_DEPTH-1:0]   vga_r_i,
    input  logic [C_DEPTH-1:0]   vga_g_i,
    input  logic [C_DEPTH-1:0]   vga_b_i,
    output logic                 pix_valid_o,
    output logic [10:0]          x_o,
    output logic [9:0]           y_o,
    output logic [3*C_DEPTH-1:0] rgb_o,
    output logic                 sof_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [15:0]          frame_cnt_o,
    output logic [7:0]           err_cnt_o
);

    localparam int HW = $clog2(H_TOTAL + 1) + 1;
    localparam int VW = $clog2(V_TOTAL + 1) + 1;

    localparam logic [HW-1:0] H_TOT = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_SYN = HW'(H_SYNC);
    localparam logic [HW-1:0] H_BEG = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_END = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [VW-1:0] V_TOT = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_SYN = VW'(V_SYNC);
    localparam logic [VW-1:0] V_BEG = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_END = VW'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 err_hist;
    logic                 err_hist_nxt;
    logic                 h_prev;
    logic                 v_prev;
    logic [HW-1:0]        h_q;
    logic [HW-1:0]        h_cur;
    logic [VW-1:0]        v_q;
    logic [VW-1:0]        v_cur;
    logic                 h_act;
    logic                 v_act;
    logic                 h_lead;
    logic                 h_trail;
    logic                 v_lead;
    logic                 v_trail;
    logic                 line_err;
    logic                 frame_err;
    logic                 err_any;
    logic                 visible;
    logic                 pix_d;
    logic                 sof_d;
    logic                 err_d;
    logic [10:0]          x_d;
    logic [9:0]           y_d;
    logic [3*C_DEPTH-1:0] rgb_d;

    assign h_act   = (h_sync_i == SYNC_POL);
    assign v_act   = (v_sync_i == SYNC_POL);
    assign h_lead  = h_act & ~h_prev;
    assign h_trail = ~h_act & h_prev;
    assign v_lead  = v_act & ~v_prev;
    assign v_trail = ~v_act & v_prev;

    // h_cur / v_cur are the counts for the current cycle; h_q / v_q hold the previous cycle's
    always_comb begin
        h_cur = h_q;
        if (h_lead)
            h_cur = '0;
        else if (h_q != H_TOT)
            h_cur = h_q + 1'b1;
    end

    always_comb begin
        v_cur = v_q;
        if (v_lead)
            v_cur = '0;
        else if (h_lead && (v_q != V_TOT))
            v_cur = v_q + 1'b1;
    end

    assign line_err  = (h_lead && ((h_q + 1'b1) != H_TOT))
                     || ((h_cur == H_TOT) && (h_q != H_TOT))
                     || (h_trail && (h_cur != H_SYN));
    assign frame_err = (v_lead && ((v_q + 1'b1) != V_TOT))
                     || ((v_cur == V_TOT) && (v_q != V_TOT))
                     || (v_trail && (v_cur != V_SYN));
    assign err_any   = line_err | frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_prev <= 1'b0;
            v_prev <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            h_prev <= h_act;
            v_prev <= v_act;
            h_q    <= h_cur;
            v_q    <= v_cur;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            err_hist <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_hist <= err_hist_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        err_hist_nxt = 1'b0;
        case (state)
            SEARCH: begin
                if (v_lead)
                    state_nxt = CHECK;
            end
            CHECK: begin
                err_hist_nxt = err_hist | err_any;
                if (v_lead) begin
                    state_nxt    = (err_hist || err_any) ? CHECK : LOCKED;
                    err_hist_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if (err_any)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        visible = (h_cur >= H_BEG) && (h_cur < H_END) && (v_cur >= V_BEG) && (v_cur < V_END);
        pix_d   = visible && (state == LOCKED) && !err_any;
        sof_d   = pix_d && (h_cur == H_BEG) && (v_cur == V_BEG);
        err_d   = (state == LOCKED) && err_any;
        x_d     = '0;
        y_d     = '0;
        rgb_d   = '0;
        if (pix_d) begin
            x_d   = 11'(h_cur - H_BEG);
            y_d   = 10'(v_cur - V_BEG);
            rgb_d = {vga_r_i, vga_g_i, vga_b_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid_o <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            rgb_o       <= '0;
            sof_o       <= 1'b0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            pix_valid_o <= pix_d;
            x_o         <= x_d;
            y_o         <= y_d;
            rgb_o       <= rgb_d;
            sof_o       <= sof_d;
            locked_o    <= (state_nxt == LOCKED);
            err_o       <= err_d;
            if (sof_d)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (err_d && (err_cnt_o != 8'hFF))
                err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
`timescale 1ns/1ps
// Bench for vga_rx on a scaled-down 16x9 timing: frame-level vector table plus
// hand-written reset sequences.
module tb_vga_rx;

    localparam int HD = 8, HS = 3, HB = 2, HT = 16;
    localparam int VD = 4, VS = 2, VB = 1, VT = 9;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB;
    localparam int NPIX = HD * VD;

    typedef enum int {K_CLEAN, K_SHORT, K_NARROW, K_WIDE, K_NOVS} kind_t;

    typedef struct {
        kind_t kind;
        int    bad_line;
        int    lock_start;
        int    lock_end;
        int    pix;
        int    sof;
        int    nerr;
        int    err_l;
        int    err_c;
        int    fc;
        int    ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_sync_i = 1'b0;
    logic        v_sync_i = 1'b0;
    logic [3:0]  vga_r_i = '0;
    logic [3:0]  vga_g_i = '0;
    logic [3:0]  vga_b_i = '0;
    logic        pix_valid_o;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [11:0] rgb_o;
    logic        sof_o;
    logic        locked_o;
    logic        err_o;
    logic [15:0] frame_cnt_o;
    logic [7:0]  err_cnt_o;

    int n_vec = 0, n_miss = 0;
    int n_pix, n_sof, n_err, n_bad, err_l, err_c, lock_start;
    int n_last = 0;
    logic [11:0] sof_rgb = '0;

    vec_t vecs[15];
    vec_t post[2];

    vga_rx #(
        .H_DISP(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISP(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_POL(1'b1), .C_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
        .vga_r_i(vga_r_i), .vga_g_i(vga_g_i), .vga_b_i(vga_b_i),
        .pix_valid_o(pix_valid_o), .x_o(x_o), .y_o(y_o), .rgb_o(rgb_o),
        .sof_o(sof_o), .locked_o(locked_o), .err_o(err_o),
        .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] colour(input int px, input int py);
        if (px == 0 && py == 0)
            return 12'hABC;
        return {px[3:0], py[3:0], 4'h5};
    endfunction

    // one pixel clock: drive, clock, then inspect the registered outputs for that cycle
    task automatic gen_cycle(input int l, input int c, input int hs_w, input bit vs_on);
        int px, py;
        bit vis;
        logic [11:0] col;
        px  = c - HOFF;
        py  = l - VOFF;
        vis = (px >= 0) && (px < HD) && (py >= 0) && (py < VD);
        col = vis ? colour(px, py) : 12'hFFF;
        h_sync_i = (c < hs_w);
        v_sync_i = vs_on;
        {vga_r_i, vga_g_i, vga_b_i} = col;
        @(posedge clk);
        #1;
        if (l == 0 && c == 0)
            lock_start = int'(locked_o);
        if (pix_valid_o) begin
            n_pix++;
            if (!vis || int'(x_o) != px || int'(y_o) != py || rgb_o != col)
                n_bad++;
            if (int'(x_o) == HD - 1 && int'(y_o) == VD - 1)
                n_last++;
        end else if (x_o != 0 || y_o != 0 || rgb_o != 0) begin
            n_bad++;
        end
        if (sof_o) begin
            n_sof++;
            sof_rgb = rgb_o;
            if (!pix_valid_o || x_o != 0 || y_o != 0)
                n_bad++;
        end
        if (err_o) begin
            n_err++;
            err_l = l;
            err_c = c;
            if (pix_valid_o)
                n_bad++;
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        n_pix = 0; n_sof = 0; n_err = 0; n_bad = 0;
        err_l = -1; err_c = -1; lock_start = -1;
        for (int l = 0; l < VT; l++) begin
            int len, hw;
            bit vs;
            len = HT;
            hw  = HS;
            vs  = (v.kind != K_NOVS) && (l < VS);
            if (l == v.bad_line) begin
                case (v.kind)
                    K_SHORT:  len = HT - 1;
                    K_NARROW: hw  = HS - 1;
                    K_WIDE:   hw  = HOFF + 1;
                    default:  ;
                endcase
            end
            for (int c = 0; c < len; c++)
                gen_cycle(l, c, hw, vs);
        end
        check($sformatf("v%0d lock_start", idx), lock_start, v.lock_start);
        check($sformatf("v%0d lock_end", idx), int'(locked_o), v.lock_end);
        check($sformatf("v%0d pix_count", idx), n_pix, v.pix);
        check($sformatf("v%0d sof_count", idx), n_sof, v.sof);
        check($sformatf("v%0d err_pulses", idx), n_err, v.nerr);
        check($sformatf("v%0d err_line", idx), err_l, v.err_l);
        check($sformatf("v%0d err_clk", idx), err_c, v.err_c);
        check($sformatf("v%0d frame_cnt", idx), int'(frame_cnt_o), v.fc);
        check($sformatf("v%0d err_cnt", idx), int'(err_cnt_o), v.ec);
        check($sformatf("v%0d pixel_data_bad", idx), n_bad, 0);
    endtask

    initial begin
        //          kind      bad  ls le pix   sof nerr el  ec  fc ec
        vecs = '{
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 0, 0},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 1, 0},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 2, 0},
            '{K_SHORT,   5,  1, 0, 24,   1,  1,   6,  0, 3, 1},
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 3, 1},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 4, 1},
            '{K_NARROW,  4,  1, 0, 8,    1,  1,   4,  2, 5, 2},
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 5, 2},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 6, 2},
            '{K_WIDE,    3,  1, 0, 1,    1,  1,   3,  6, 7, 3},
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 7, 3},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 8, 3},
            '{K_NOVS,   -1,  0, 0, 0,    0,  1,   0,  0, 8, 4},
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 8, 4},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 9, 4}
        };
        post = '{
            '{K_CLEAN,  -1,  0, 0, 0,    0,  0,  -1, -1, 0, 0},
            '{K_CLEAN,  -1,  1, 1, NPIX, 1,  0,  -1, -1, 1, 0}
        };

        #2 rst = 1'b0;
        #1;
        check("reset flags", int'({pix_valid_o, sof_o, locked_o, err_o}), 0);
        check("reset x_y", int'(x_o) + int'(y_o), 0);
        check("reset rgb", int'(rgb_o), 0);
        check("reset counters", int'(frame_cnt_o) + int'(err_cnt_o), 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset held flags", int'({pix_valid_o, sof_o, locked_o, err_o}), 0);
        rst = 1'b1;

        for (int c = 0; c < 5; c++)
            gen_cycle(-1, c, 0, 1'b0);

        for (int i = 0; i < 15; i++)
            run_frame(vecs[i], i);

        check("first pixel colour", int'(sof_rgb), 12'hABC);
        check("last pixel seen", n_last, 6);

        // mid-line asynchronous reset while locked
        n_bad = 0; n_err = 0;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < HT; c++)
                gen_cycle(l, c, HS, l < VS);
        for (int c = 0; c < 8; c++)
            gen_cycle(3, c, HS, 1'b0);
        check("pre-reset pix_valid", int'(pix_valid_o), 1);
        check("pre-reset x", int'(x_o), 2);
        rst = 1'b0;
        #1;
        check("mid reset flags", int'({pix_valid_o, sof_o, locked_o, err_o}), 0);
        check("mid reset x_y", int'(x_o) + int'(y_o), 0);
        check("mid reset rgb", int'(rgb_o), 0);
        check("mid reset frame_cnt", int'(frame_cnt_o), 0);
        check("mid reset err_cnt", int'(err_cnt_o), 0);
        for (int c = 8; c < HT; c++)
            gen_cycle(3, c, HS, 1'b0);
        rst = 1'b1;
        for (int l = 4; l < VT; l++)
            for (int c = 0; c < HT; c++)
                gen_cycle(l, c, HS, 1'b0);
        check("reset no err pulse", n_err, 0);
        check("reset outputs bad", n_bad, 0);
        check("reset stays unlocked", int'(locked_o), 0);

        run_frame(post[0], 15);
        run_frame(post[1], 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
